// File: rtl/spi_fifo_ctl.sv
// spi_fifo_ctl: TX/RX FIFO front end for an SPI engine.
// TX entries are {fast, data[31:0]}; RX is first-word-fall-through.
// Optional chip-select output spi_cs_n when SPI_FIFO_CTL_CS_EN is defined.
module spi_fifo_ctl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_wr,
    input  logic        tx_fast,
    input  logic [31:0] tx_data,
    output logic        tx_full,
    input  logic        rx_rd,
    output logic [31:0] rx_data,
    output logic        rx_empty,
    output logic        busy,
    output logic        spi_start,
    output logic        spi_fast,
    output logic [31:0] spi_dataTx,
    input  logic [31:0] spi_dataRx,
    input  logic        spi_rdy
`ifdef SPI_FIFO_CTL_CS_EN
    ,
    output logic        spi_cs_n
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, CAPT} state_t;
    state_t state_q, state_d;

    logic [32:0]   tx_mem_q [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q;
    logic [CW-1:0] tx_cnt_q;
    logic [31:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q;
    logic [CW-1:0] rx_cnt_q;
    logic          fast_q;
    logic [31:0]   data_q;

    logic          tx_push, tx_pop, rx_push, rx_pop, can_issue;
    logic [32:0]   tx_head;
    logic [31:0]   rx_wdata;

    assign tx_full   = (tx_cnt_q == FULL_CNT);
    assign rx_empty  = (rx_cnt_q == '0);
    assign tx_push   = tx_wr & ~tx_full;
    assign tx_pop    = (state_q == ISSUE);
    assign rx_push   = (state_q == CAPT);
    assign rx_pop    = rx_rd & ~rx_empty;
    assign tx_head   = tx_mem_q[tx_rp_q];
    assign rx_wdata  = fast_q ? spi_dataRx : {24'h0, spi_dataRx[7:0]};
    assign rx_data   = rx_empty ? '0 : rx_mem_q[rx_rp_q];
    assign busy      = (tx_cnt_q != '0) || (state_q != IDLE);
    assign spi_start = (state_q == ISSUE);
    assign spi_fast  = fast_q;
    assign spi_dataTx = data_q;

    // Any non-IDLE state holds one RX slot reserved for the word in flight.
    assign can_issue = (tx_cnt_q != '0)
                    && ((rx_cnt_q + CW'(state_q != IDLE)) < FULL_CNT)
                    && spi_rdy;

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (can_issue) state_d = ISSUE;
            ISSUE:   state_d = ARM;
            ARM:     state_d = WAIT;
            WAIT:    if (spi_rdy) state_d = CAPT;
            CAPT:    state_d = can_issue ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, counts and the latched transfer word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            fast_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
            // Latch on entry to ISSUE so mode/data are already valid on the start cycle.
            if (state_d == ISSUE) begin
                fast_q <= tx_head[32];
                data_q <= tx_head[31:0];
            end
        end
    end

    // FIFO storage; contents need no reset since counts gate visibility.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= {tx_fast, tx_data};
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_wdata;
    end

`ifdef SPI_FIFO_CTL_CS_EN
    logic cs_n_q, cs_n_d, capt_q;

    // Chip select drops on ISSUE and is released one cycle after the final capture.
    always_comb begin
        cs_n_d = cs_n_q;
        if (state_d == ISSUE)
            cs_n_d = 1'b0;
        else if (capt_q && (state_q == IDLE) && (tx_cnt_q == '0))
            cs_n_d = 1'b1;
    end

    // Chip-select register and delayed capture flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_q <= 1'b1;
            capt_q <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            capt_q <= (state_q == CAPT);
        end
    end

    assign spi_cs_n = cs_n_q;
`endif

endmodule
